// File: rtl/mem_arbiter.sv
// Memory port arbiter between the 6502 core and a single DMA requester.
// The CPU owns the port by default; DMA is granted only after halting the core via RDY.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 16,
  parameter int MIN_CPU_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  input  logic                  cpu_wr_enable,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_rdy,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_address,
  input  logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_wr_enable,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rd_data,
  output logic                  dma_rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_enable,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CYC_W   = $clog2(MIN_CPU_CYCLES + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [CYC_W-1:0]   CYC_MIN    = CYC_W'(MIN_CPU_CYCLES);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_HALT,
    ST_DMA,
    ST_RELEASE
  } state_t;

  state_t             state;
  logic [CYC_W-1:0]   cpu_cycles;
  logic [BURST_W-1:0] burst_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_CPU;
      cpu_cycles   <= '0;
      burst_cnt    <= '0;
      dma_rd_valid <= 1'b0;
    end else begin
      dma_rd_valid <= dma_ack && !dma_wr_enable;
      unique case (state)
        ST_CPU: begin
          if (cpu_cycles != CYC_MIN) cpu_cycles <= cpu_cycles + 1'b1;
          if (dma_req && (cpu_cycles >= CYC_MIN)) state <= ST_HALT;
        end
        // The core only stops on a read cycle, so pending stack writes must drain first.
        ST_HALT: begin
          if (!dma_req) begin
            state <= ST_RELEASE;
          end else if (!cpu_wr_enable) begin
            state     <= ST_DMA;
            burst_cnt <= '0;
          end
        end
        ST_DMA: begin
          if (dma_req) burst_cnt <= burst_cnt + 1'b1;
          if (!dma_req || (burst_cnt == BURST_LAST)) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          state      <= ST_CPU;
          cpu_cycles <= '0;
        end
        default: state <= ST_CPU;
      endcase
    end
  end

  // RELEASE keeps rdy low one more cycle so the stalled read address is re-presented.
  always_comb begin
    cpu_rdy       = 1'b1;
    dma_gnt       = 1'b0;
    dma_ack       = 1'b0;
    mem_address   = cpu_address;
    mem_wr_data   = cpu_wr_data;
    mem_wr_enable = cpu_wr_enable;
    unique case (state)
      ST_CPU: ;
      ST_HALT, ST_RELEASE: cpu_rdy = 1'b0;
      ST_DMA: begin
        cpu_rdy       = 1'b0;
        dma_gnt       = 1'b1;
        dma_ack       = dma_req;
        mem_address   = dma_address;
        mem_wr_data   = dma_wr_data;
        mem_wr_enable = dma_req && dma_wr_enable;
      end
      default: ;
    endcase
    if (!resetn) mem_wr_enable = 1'b0;
  end

  assign cpu_rd_data = mem_rd_data;
  assign dma_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against an ownership-level reference model and shadow memory.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXB = 16;
  localparam int MINC = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_enable;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rdy;
  logic          dma_req;
  logic [AW-1:0] dma_address;
  logic [DW-1:0] dma_wr_data;
  logic          dma_wr_enable;
  logic          dma_gnt;
  logic          dma_ack;
  logic [DW-1:0] dma_rd_data;
  logic          dma_rd_valid;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_enable;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .MIN_CPU_CYCLES(MINC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cpu_address(cpu_address), .cpu_wr_data(cpu_wr_data), .cpu_wr_enable(cpu_wr_enable),
    .cpu_rd_data(cpu_rd_data), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_address(dma_address), .dma_wr_data(dma_wr_data),
    .dma_wr_enable(dma_wr_enable), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .dma_rd_data(dma_rd_data), .dma_rd_valid(dma_rd_valid),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
    .mem_rd_data(mem_rd_data)
  );

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'h9000) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  // Memory block seen by the DUT, synchronous read.
  bit [7:0] env_data    [65536];
  bit       env_written [65536];
  always @(posedge clk) begin
    mem_rd_data <= env_written[mem_address] ? env_data[mem_address] : init_val(mem_address);
    if (mem_wr_enable) begin
      env_data[mem_address]    <= mem_wr_data;
      env_written[mem_address] <= 1'b1;
    end
  end

  // Reference model: who holds the port, plus a shadow copy of memory.
  bit [7:0] ref_data    [65536];
  bit       ref_written [65536];
  bit       m_halting, m_granted, m_releasing;
  int       free_cycles, grant_acks;
  bit       exp_rd_valid, read_pending;
  logic [7:0] exp_read_byte;

  int  checks = 0;
  int  failures = 0;
  bit  obs_rdy, obs_gnt, obs_ack, obs_we, last_exp_ack;
  logic [15:0] obs_addr;
  int  dma_left = 0;
  int  cpu_writes_left = 0;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit model_rdy();
    return !(m_halting || m_granted || m_releasing);
  endfunction

  task automatic model_reset();
    m_halting = 0; m_granted = 0; m_releasing = 0;
    free_cycles = 0; grant_acks = 0;
    exp_rd_valid = 0; read_pending = 0; last_exp_ack = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic run_cycle();
    logic e_rdy, e_gnt, e_ack, e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    #1;
    e_rdy  = model_rdy();
    e_gnt  = m_granted;
    e_ack  = m_granted && dma_req;
    e_addr = m_granted ? dma_address : cpu_address;
    e_we   = m_granted ? (dma_req && dma_wr_enable) : cpu_wr_enable;
    e_wd   = m_granted ? dma_wr_data : cpu_wr_data;
    check_output("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
    check_output("dma_gnt", 32'(dma_gnt), 32'(e_gnt));
    check_output("dma_ack", 32'(dma_ack), 32'(e_ack));
    check_output("mem_address", 32'(mem_address), 32'(e_addr));
    check_output("mem_wr_enable", 32'(mem_wr_enable), 32'(e_we));
    if (e_we) check_output("mem_wr_data", 32'(mem_wr_data), 32'(e_wd));
    check_output("dma_rd_valid", 32'(dma_rd_valid), 32'(exp_rd_valid));
    if (exp_rd_valid) check_output("dma_rd_data", 32'(dma_rd_data), 32'(exp_read_byte));
    if (read_pending) check_output("cpu_rd_data", 32'(cpu_rd_data), 32'(exp_read_byte));
    obs_rdy = cpu_rdy; obs_gnt = dma_gnt; obs_ack = dma_ack;
    obs_we = mem_wr_enable; obs_addr = mem_address;
    last_exp_ack = e_ack;
    @(posedge clk);
    read_pending  = !e_we;
    exp_read_byte = ref_written[e_addr] ? ref_data[e_addr] : init_val(e_addr);
    exp_rd_valid  = e_ack && !dma_wr_enable;
    if (e_we) begin
      ref_data[e_addr]    = e_wd;
      ref_written[e_addr] = 1'b1;
    end
    if (e_rdy) begin
      if (dma_req && free_cycles >= MINC) m_halting = 1;
      free_cycles++;
    end else if (m_halting) begin
      if (!dma_req) begin
        m_halting = 0; m_releasing = 1;
      end else if (!cpu_wr_enable) begin
        m_halting = 0; m_granted = 1; grant_acks = 0;
      end
    end else if (m_granted) begin
      if (e_ack) grant_acks++;
      if (!dma_req || grant_acks == MAXB) begin
        m_granted = 0; m_releasing = 1;
      end
    end else begin
      m_releasing = 0; free_cycles = 0;
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus();
    if (dma_req && last_exp_ack) begin
      dma_left--;
      dma_address   = 16'($urandom);
      dma_wr_data   = 8'($urandom);
      dma_wr_enable = 1'($urandom);
    end
    if (dma_left == 0 && $urandom_range(0, 5) == 0) dma_left = $urandom_range(1, 20);
    dma_req = (dma_left > 0);
    if (cpu_writes_left > 0) begin
      cpu_writes_left--;
      cpu_wr_enable = 1; cpu_address = 16'h0100 | 16'($urandom_range(0, 255));
      cpu_wr_data = 8'($urandom);
    end else if (model_rdy()) begin
      if ($urandom_range(0, 5) == 0) begin
        cpu_writes_left = $urandom_range(0, 2);
        cpu_wr_enable = 1; cpu_address = 16'h0100 | 16'($urandom_range(0, 255));
        cpu_wr_data = 8'($urandom);
      end else begin
        cpu_wr_enable = 0; cpu_address = 16'($urandom);
      end
    end else if (cpu_wr_enable) begin
      cpu_wr_enable = 0; cpu_address = 16'($urandom);
    end
  endtask

  initial begin
    int acks, wr_hits, rdy_low, high_cnt, cur_burst, gap, min_gap, remaining;
    bit seen_valid, seen_resume, seen_gnt, in_gap;
    int bursts[$];

    resetn = 0;
    cpu_address = 16'h8000; cpu_wr_data = 0; cpu_wr_enable = 0;
    dma_req = 0; dma_address = 0; dma_wr_data = 0; dma_wr_enable = 0;
    #1;
    check_output("reset_cpu_rdy", 32'(cpu_rdy), 1);
    check_output("reset_dma_gnt", 32'(dma_gnt), 0);
    check_output("reset_dma_rd_valid", 32'(dma_rd_valid), 0);
    repeat (2) @(negedge clk);
    model_reset();
    resetn = 1;

    // CPU alone: port follows the core.
    cpu_address = 16'h8000; run_cycle();
    cpu_address = 16'h8001; run_cycle();

    // Single DMA write.
    cpu_address = 16'h8002;
    dma_req = 1; dma_address = 16'h0200; dma_wr_data = 8'h5A; dma_wr_enable = 1;
    acks = 0; wr_hits = 0; rdy_low = 0;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      acks += int'(obs_ack);
      rdy_low += int'(!obs_rdy);
      if (obs_we && obs_addr == 16'h0200) wr_hits++;
      if (last_exp_ack) dma_req = 0;
    end
    check_output("t2_acks", 32'(acks), 1);
    check_output("t2_write_cycles", 32'(wr_hits), 1);
    check_output("t2_mem_0200", 32'(env_data[16'h0200]), 32'h5A);
    check_output("t2_rdy_low_min", 32'(rdy_low >= 3), 1);

    // DMA request during three back-to-back CPU pushes.
    cpu_address = 16'h8003; run_cycle(); run_cycle(); run_cycle();
    dma_req = 1; dma_address = 16'h4000; dma_wr_enable = 0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      cpu_wr_enable = 1; cpu_address = 16'(16'h01FF - k); cpu_wr_data = 8'(8'hD0 + k);
      run_cycle();
      acks += int'(obs_ack);
    end
    check_output("t3_no_ack_during_writes", 32'(acks), 0);
    cpu_wr_enable = 0; cpu_address = 16'h8010;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      acks += int'(obs_ack);
      if (last_exp_ack) dma_req = 0;
    end
    check_output("t3_acks", 32'(acks), 1);
    check_output("t3_push0", 32'(env_data[16'h01FF]), 32'hD0);
    check_output("t3_push1", 32'(env_data[16'h01FE]), 32'hD1);
    check_output("t3_push2", 32'(env_data[16'h01FD]), 32'hD2);

    // DMA read of 0x9000 while the CPU is stalled on 0x1234.
    cpu_address = 16'h1234;
    dma_req = 1; dma_address = 16'h9000; dma_wr_enable = 0;
    seen_valid = 0; seen_resume = 0;
    for (int i = 0; i < 14; i++) begin
      run_cycle();
      if (obs_ack) begin
        seen_valid = 1;
        check_output("t5_rd_valid", 32'(dma_rd_valid), 1);
        check_output("t5_rd_data", 32'(dma_rd_data), 32'hA5);
      end
      if (!obs_rdy && cpu_rdy) begin
        seen_resume = 1;
        check_output("t5_cpu_resume_data", 32'(cpu_rd_data), 32'(init_val(16'h1234)));
      end
      if (last_exp_ack) dma_req = 0;
    end
    check_output("t5_valid_seen", 32'(seen_valid), 1);
    check_output("t5_resume_seen", 32'(seen_resume), 1);

    // Long DMA stream split into capped bursts.
    cpu_address = 16'h8100; dma_wr_enable = 1;
    remaining = 40; cur_burst = 0; min_gap = 1000; gap = 0; in_gap = 0; acks = 0;
    dma_req = 1; dma_address = 16'h3000; dma_wr_data = 8'h00;
    for (int i = 0; i < 200 && (remaining > 0 || obs_gnt || !obs_rdy); i++) begin
      run_cycle();
      if (obs_ack) begin cur_burst++; acks++; end
      if (obs_gnt) begin
        if (in_gap && gap < min_gap) min_gap = gap;
        in_gap = 0;
      end else if (cur_burst > 0) begin
        bursts.push_back(cur_burst);
        cur_burst = 0; in_gap = 1; gap = 0;
      end
      if (in_gap && obs_rdy) gap++;
      if (last_exp_ack) begin
        remaining--;
        dma_address = 16'(16'h3000 + 40 - remaining);
        dma_wr_data = 8'(40 - remaining);
      end
      dma_req = (remaining > 0);
    end
    check_output("t4_total_acks", 32'(acks), 40);
    check_output("t4_burst_count", 32'(bursts.size()), 3);
    if (bursts.size() == 3) begin
      check_output("t4_burst0", 32'(bursts[0]), 16);
      check_output("t4_burst1", 32'(bursts[1]), 16);
      check_output("t4_burst2", 32'(bursts[2]), 8);
    end
    check_output("t4_min_cpu_gap", 32'(min_gap >= MINC), 1);

    // Reset asserted in the middle of a burst.
    cpu_address = 16'h8200; dma_req = 1; dma_address = 16'h5000; dma_wr_enable = 1;
    acks = 0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      run_cycle();
      acks += int'(obs_ack);
    end
    check_output("t6_pre_gnt", 32'(dma_gnt), 1);
    resetn = 0;
    #1;
    check_output("t6_rst_cpu_rdy", 32'(cpu_rdy), 1);
    check_output("t6_rst_dma_gnt", 32'(dma_gnt), 0);
    check_output("t6_rst_dma_ack", 32'(dma_ack), 0);
    check_output("t6_rst_mem_wr_enable", 32'(mem_wr_enable), 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    resetn = 1;
    high_cnt = 0; seen_gnt = 0;
    for (int i = 0; i < 20 && !seen_gnt; i++) begin
      run_cycle();
      if (obs_gnt) seen_gnt = 1;
      else if (obs_rdy) high_cnt++;
    end
    check_output("t6_grant_seen", 32'(seen_gnt), 1);
    check_output("t6_cpu_cycles_before_grant", 32'(high_cnt), 32'(MINC + 1));
    dma_req = 0;
    for (int i = 0; i < 4; i++) run_cycle();

    // Random traffic.
    dma_left = 0; cpu_writes_left = 0;
    for (int i = 0; i < 800; i++) begin
      apply_stimulus();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
